// File: rtl/crypto_decrypt.sv
// ---------------------------------------------------------------------------
// crypto_decrypt
//
// Receive-side AXI-Stream decryptor. It undoes the switch's XOR encryptor so
// that plaintext packets reach the output port lookup.
//
// Packet layout seen by this block:
//   word 0          : Ethernet header, passed in clear
//   word 1 [15:0]   : passed in clear
//   word 1 [255:16] : XOR {7{key}, key[31:16]}
//   word 2..n       : XOR {8{key}}
//
// The key and bypass inputs are latched on the first beat of every packet.
// Changes made to them in the middle of a packet take effect on the next
// packet. tkeep does not gate the XOR. tkeep, tuser and tlast pass through
// unchanged.
//
// Ports:
//   axis_aclk, axis_resetn       clock, asynchronous active-low reset
//   s_axis_*                     slave stream (tdata/tkeep/tuser/tvalid/tlast in,
//                                tready out)
//   m_axis_*                     master stream (registered outputs, tready in)
//   key                          32-bit key, sampled on the first beat only
//   bypass                       1 = pass the packet unmodified, sampled on
//                                the first beat only
//   pkt_cnt                      count of packets emitted with decryption
//                                applied; wraps
//
// Only 256-bit tdata is supported. The slave widths must equal the master
// widths.
// ---------------------------------------------------------------------------
module crypto_decrypt #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
    input  logic                                axis_aclk,
    input  logic                                axis_resetn,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
    input  logic                                s_axis_tvalid,
    output logic                                s_axis_tready,
    input  logic                                s_axis_tlast,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic                                m_axis_tlast,

    input  logic [31:0]                         key,
    input  logic                                bypass,
    output logic [31:0]                         pkt_cnt
);

    localparam int DATA_W = C_M_AXIS_DATA_WIDTH;
    localparam int KEEP_W = C_M_AXIS_DATA_WIDTH / 8;
    localparam int USER_W = C_M_AXIS_TUSER_WIDTH;

    typedef enum logic [1:0] {
        HDR0    = 2'd0,
        HDR1    = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    // Word 1 keeps its low 16 bits (EtherType) in clear. The key stream
    // therefore starts at bit 16 and ends with the upper half of the key.
    function automatic logic [DATA_W-1:0] hdr1_mask(input logic [31:0] k);
        return {{7{k}}, k[31:16], 16'h0000};
    endfunction

    function automatic logic [DATA_W-1:0] payload_mask(input logic [31:0] k);
        return {8{k}};
    endfunction

    // Packet-tracking state
    state_t              state_q, state_d;
    logic [31:0]         active_key_q, active_key_d;
    logic                active_bypass_q, active_bypass_d;

    // Output register stage
    logic [DATA_W-1:0]   tdata_q, tdata_d;
    logic [KEEP_W-1:0]   tkeep_q, tkeep_d;
    logic [USER_W-1:0]   tuser_q, tuser_d;
    logic                tlast_q, tlast_d;
    logic                tvalid_q, tvalid_d;
    logic [31:0]         pkt_cnt_q, pkt_cnt_d;

    logic                in_acc;
    logic                out_acc;
    logic                eff_bypass;
    logic [DATA_W-1:0]   xor_mask;

    // The single output register can take a new beat when it is empty or
    // when its current beat leaves on this same edge.
    assign s_axis_tready = !tvalid_q || m_axis_tready;
    assign in_acc        = s_axis_tvalid && s_axis_tready;
    assign out_acc       = tvalid_q && m_axis_tready;

    // Next-state logic and per-beat mask selection
    always_comb begin
        state_d         = state_q;
        active_key_d    = active_key_q;
        active_bypass_d = active_bypass_q;
        eff_bypass      = active_bypass_q;
        xor_mask        = '0;

        case (state_q)
            HDR0: begin
                // The header beat uses the live bypass input because that
                // beat is the one that latches it for the rest of the packet.
                eff_bypass = bypass;
                if (in_acc) begin
                    active_key_d    = key;
                    active_bypass_d = bypass;
                    state_d         = s_axis_tlast ? HDR0 : HDR1;
                end
            end
            HDR1: begin
                xor_mask = hdr1_mask(active_key_q);
                if (in_acc) begin
                    state_d = s_axis_tlast ? HDR0 : PAYLOAD;
                end
            end
            PAYLOAD: begin
                xor_mask = payload_mask(active_key_q);
                if (in_acc && s_axis_tlast) begin
                    state_d = HDR0;
                end
            end
            default: begin
                state_d = HDR0;
            end
        endcase

        if (eff_bypass) begin
            xor_mask = '0;
        end
    end

    // Output register load / drain and packet counter
    always_comb begin
        tdata_d   = tdata_q;
        tkeep_d   = tkeep_q;
        tuser_d   = tuser_q;
        tlast_d   = tlast_q;
        tvalid_d  = tvalid_q;
        pkt_cnt_d = pkt_cnt_q;

        if (in_acc) begin
            tdata_d  = s_axis_tdata ^ xor_mask;
            tkeep_d  = s_axis_tkeep;
            tuser_d  = s_axis_tuser;
            tlast_d  = s_axis_tlast;
            tvalid_d = 1'b1;
            if (s_axis_tlast && !eff_bypass) begin
                pkt_cnt_d = pkt_cnt_q + 32'd1;
            end
        end else if (out_acc) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q         <= HDR0;
            active_key_q    <= '0;
            active_bypass_q <= 1'b0;
            tdata_q         <= '0;
            tkeep_q         <= '0;
            tuser_q         <= '0;
            tlast_q         <= 1'b0;
            tvalid_q        <= 1'b0;
            pkt_cnt_q       <= '0;
        end else begin
            state_q         <= state_d;
            active_key_q    <= active_key_d;
            active_bypass_q <= active_bypass_d;
            tdata_q         <= tdata_d;
            tkeep_q         <= tkeep_d;
            tuser_q         <= tuser_d;
            tlast_q         <= tlast_d;
            tvalid_q        <= tvalid_d;
            pkt_cnt_q       <= pkt_cnt_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tvalid = tvalid_q;
    assign pkt_cnt       = pkt_cnt_q;

endmodule
